// File: rtl/mips_wb_pkg.sv
// mips_wb_pkg -- shared types for the MIPS write-back stage.
//   wb_op_t          : memory/write-back operation code (9..15 illegal)
//   BE_ALL / BE_NONE : register-file byte-enable constants
//   is_load()        : true for LB..LWR (drives the load-use stall hint)
package mips_wb_pkg;

  typedef enum logic [3:0] {
    OP_NONE = 4'd0,
    OP_ALU  = 4'd1,
    OP_LB   = 4'd2,
    OP_LBU  = 4'd3,
    OP_LH   = 4'd4,
    OP_LHU  = 4'd5,
    OP_LW   = 4'd6,
    OP_LWL  = 4'd7,
    OP_LWR  = 4'd8
  } wb_op_t;

  localparam logic [3:0] BE_ALL  = 4'b1111;
  localparam logic [3:0] BE_NONE = 4'b0000;

  // LWL/LWR count as loads even when the unaligned ops are compiled out,
  // so upstream still stalls on them.
  function automatic logic is_load(input logic [3:0] op);
    return (op >= 4'(OP_LB)) && (op <= 4'(OP_LWR));
  endfunction

endpackage

// File: rtl/mips_wb_stage_if.sv
// mips_wb_stage_if -- memory-stage request and register-file write bundle.
//   in_valid/in_op/in_addr_lo/in_alu_res/in_rd : instruction entering stage M
//   flush      : kill the instruction currently held in M
//   mem_rdata  : data-memory word for the instruction in M
//   Rd_addr/Rd_in/Rd_Byte_w_en : registered register-file write port
//   exc        : one-cycle misaligned/illegal pulse
//   ld_busy/ld_busy_rd : load sitting in M, for load-use stall
//   master = upstream pipeline / memory side, slave = mips_wb_stage.
interface mips_wb_stage_if;
  logic        in_valid;
  logic [3:0]  in_op;
  logic [1:0]  in_addr_lo;
  logic [31:0] in_alu_res;
  logic [4:0]  in_rd;
  logic        flush;
  logic [31:0] mem_rdata;
  logic [4:0]  Rd_addr;
  logic [31:0] Rd_in;
  logic [3:0]  Rd_Byte_w_en;
  logic        exc;
  logic        ld_busy;
  logic [4:0]  ld_busy_rd;

  modport master (
    output in_valid, in_op, in_addr_lo, in_alu_res, in_rd, flush, mem_rdata,
    input  Rd_addr, Rd_in, Rd_Byte_w_en, exc, ld_busy, ld_busy_rd
  );

  modport slave (
    input  in_valid, in_op, in_addr_lo, in_alu_res, in_rd, flush, mem_rdata,
    output Rd_addr, Rd_in, Rd_Byte_w_en, exc, ld_busy, ld_busy_rd
  );
endinterface

// File: rtl/mips_load_align.sv
// mips_load_align -- combinational load data alignment.
//   op, addr_lo, alu_res, mem_rdata in -> data (unwritten lanes 0),
//   be (byte enables), err (misaligned or illegal op).
// Macro WB_LWLR_EN: when defined LWL/LWR merge partial words; otherwise
// they are reported as illegal.
module mips_load_align
  import mips_wb_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] alu_res,
  input  logic [31:0] mem_rdata,
  output logic [31:0] data,
  output logic [3:0]  be,
  output logic        err
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = mem_rdata[{addr_lo, 3'b000} +: 8];
    half_sel = mem_rdata[{addr_lo[1], 4'b0000} +: 16];
    data     = '0;
    be       = BE_NONE;
    err      = 1'b0;
    case (op)
      OP_NONE: be = BE_NONE;
      OP_ALU: begin data = alu_res; be = BE_ALL; end
      OP_LB:  begin data = {{24{byte_sel[7]}}, byte_sel}; be = BE_ALL; end
      OP_LBU: begin data = {24'h0, byte_sel}; be = BE_ALL; end
      OP_LH, OP_LHU: begin
        if (addr_lo[0]) err = 1'b1;
        else begin
          data = {{16{half_sel[15] & (op == 4'(OP_LH))}}, half_sel};
          be   = BE_ALL;
        end
      end
      OP_LW: begin
        if (addr_lo != 2'd0) err = 1'b1;
        else begin data = mem_rdata; be = BE_ALL; end
      end
`ifdef WB_LWLR_EN
      // LWL: low k+1 memory bytes slide up to the top of the register.
      OP_LWL: begin
        data = mem_rdata << {~addr_lo, 3'b000};
        be   = BE_ALL << ~addr_lo;
      end
      // LWR: memory bytes k..3 slide down to the bottom of the register.
      OP_LWR: begin
        data = mem_rdata >> {addr_lo, 3'b000};
        be   = BE_ALL >> addr_lo;
      end
`endif
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_wb_stage.sv
// mips_wb_stage -- two-stage memory/write-back pipeline.
//   clk, rst : single clock, synchronous active-high reset
//   bus      : mips_wb_stage_if.slave (instruction in, register-file write out)
// Stage M holds the instruction while the synchronous memory returns its
// word; stage W registers the aligned write and the exception pulse.
// Macro WB_LWLR_EN enables LWL/LWR (see mips_load_align).
module mips_wb_stage
  import mips_wb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  mips_wb_stage_if.slave    bus
);

  logic        m_valid_q, m_valid_d;
  logic [3:0]  m_op_q, m_op_d;
  logic [1:0]  m_addr_lo_q, m_addr_lo_d;
  logic [31:0] m_alu_res_q, m_alu_res_d;
  logic [4:0]  m_rd_q, m_rd_d;

  logic [4:0]  rd_addr_q, rd_addr_d;
  logic [31:0] rd_in_q, rd_in_d;
  logic [3:0]  rd_be_q, rd_be_d;
  logic        exc_q, exc_d;

  logic [31:0] al_data;
  logic [3:0]  al_be;
  logic        al_err;
  logic        wr_live;

  mips_load_align u_align (
    .op        (m_op_q),
    .addr_lo   (m_addr_lo_q),
    .alu_res   (m_alu_res_q),
    .mem_rdata (bus.mem_rdata),
    .data      (al_data),
    .be        (al_be),
    .err       (al_err)
  );

  // M: refill every cycle; payload only loads on a real instruction.
  always_comb begin
    m_valid_d   = bus.in_valid;
    m_op_d      = bus.in_valid ? bus.in_op      : m_op_q;
    m_addr_lo_d = bus.in_valid ? bus.in_addr_lo : m_addr_lo_q;
    m_alu_res_d = bus.in_valid ? bus.in_alu_res : m_alu_res_q;
    m_rd_d      = bus.in_valid ? bus.in_rd      : m_rd_q;
  end

  // W: flush kills the M occupant on this edge. Faults report even for
  // rd=0; a clean op to r0 is silently dropped.
  always_comb begin
    wr_live   = m_valid_q && !bus.flush;
    exc_d     = wr_live && al_err;
    rd_be_d   = (wr_live && !al_err && (m_rd_q != 5'd0)) ? al_be : BE_NONE;
    rd_addr_d = (rd_be_d != BE_NONE) ? m_rd_q  : 5'd0;
    rd_in_d   = (rd_be_d != BE_NONE) ? al_data : 32'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_q   <= 1'b0;
      m_op_q      <= '0;
      m_addr_lo_q <= '0;
      m_alu_res_q <= '0;
      m_rd_q      <= '0;
      rd_addr_q   <= '0;
      rd_in_q     <= '0;
      rd_be_q     <= BE_NONE;
      exc_q       <= 1'b0;
    end else begin
      m_valid_q   <= m_valid_d;
      m_op_q      <= m_op_d;
      m_addr_lo_q <= m_addr_lo_d;
      m_alu_res_q <= m_alu_res_d;
      m_rd_q      <= m_rd_d;
      rd_addr_q   <= rd_addr_d;
      rd_in_q     <= rd_in_d;
      rd_be_q     <= rd_be_d;
      exc_q       <= exc_d;
    end
  end

  assign bus.Rd_addr      = rd_addr_q;
  assign bus.Rd_in        = rd_in_q;
  assign bus.Rd_Byte_w_en = rd_be_q;
  assign bus.exc          = exc_q;
  assign bus.ld_busy      = m_valid_q && is_load(m_op_q);
  assign bus.ld_busy_rd   = bus.ld_busy ? m_rd_q : 5'd0;

endmodule

// File: doc/mips_wb_stage.md
MIPS_WB_STAGE -- requirements
Module: mips_wb_stage

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock for all state.
REQ-002 SHALL have: rst  in  1  synchronous active-high reset; one clock, no other clock or reset.
REQ-003 SHALL have: in_valid  in  1  memory-stage instruction present this cycle.
REQ-004 SHALL have: in_op  in  4  wb_op_t operation code.
REQ-005 SHALL have: in_addr_lo  in  2  effective-address bits [1:0].
REQ-006 SHALL have: in_alu_res  in  32  ALU result.
REQ-007 SHALL have: in_rd  in  5  destination register.
REQ-008 SHALL have: flush  in  1  kill the instruction held in stage M.
REQ-009 SHALL have: mem_rdata  in  32  synchronous data-memory word, valid the cycle after in_valid.
REQ-010 SHALL have: Rd_addr  out  5, Rd_in  out  32, Rd_Byte_w_en  out  4  register-file write port, all registered.
REQ-011 SHALL have: exc  out  1  one-cycle pulse on misaligned or illegal op.
REQ-012 SHALL have: ld_busy  out  1, ld_busy_rd  out  5  load occupying stage M, for upstream load-use stall.

Function
REQ-013 SHALL be two stages: M captures op/addr_lo/alu_res/rd when in_valid; W registers aligned data and byte enables.
REQ-014 SHALL give latency 2: in_valid at edge N -> Rd_* valid after edge N+2, held for exactly one cycle.
REQ-015 SHALL accept one instruction per cycle, no backpressure; M overwritten every cycle (invalid when in_valid=0).
REQ-016 SHALL encode wb_op_t: NONE=0, ALU=1, LB=2, LBU=3, LH=4, LHU=5, LW=6, LWL=7, LWR=8; codes 9-15 illegal.
REQ-017 SHALL use little-endian byte lanes: byte k = mem_rdata[8k+7:8k].
REQ-018 ALU: Rd_in=alu_res, enables 1111.
REQ-019 LB/LBU: byte addr_lo sign/zero-extended to 32, enables 1111.
REQ-020 LH/LHU: half addr_lo[1] sign/zero-extended, enables 1111; addr_lo[0]=1 -> misaligned.
REQ-021 LW: whole word, enables 1111; addr_lo!=0 -> misaligned.
REQ-022 LWL k=addr_lo: mem bytes 0..k placed in register top bytes; enables k=0:1000, 1:1100, 2:1110, 3:1111.
REQ-023 LWR k=addr_lo: mem bytes k..3 placed in register low bytes; enables k=0:1111, 1:0111, 2:0011, 3:0001.
REQ-024 Unwritten byte lanes of Rd_in SHALL be 0.
REQ-025 Misaligned or illegal op: enables 0000, exc=1 in the W-output cycle, no write.
REQ-026 in_rd=0 SHALL force enables 0000 (no exc); NONE -> enables 0000.
REQ-027 flush=1 SHALL invalidate M on the same edge; flushed instruction produces no write and no exc; in_valid with flush in the same cycle is captured normally (flush applies to prior M content).
REQ-028 ld_busy=1 iff M valid and op is a load (LB..LWR); ld_busy_rd=M rd, else 0.
REQ-029 When enables=0000, Rd_addr and Rd_in SHALL be 0.

Reset
REQ-030 rst SHALL clear M and W valid; all outputs 0 the cycle after the reset edge.
REQ-031 rst mid-operation SHALL drop in-flight instructions with no write or exc; rst dominates flush and in_valid.

Configuration
REQ-032 Macro WB_LWLR_EN defined: LWL/LWR per REQ-022/023.
REQ-033 WB_LWLR_EN undefined: LWL/LWR treated as illegal (REQ-025); ld_busy still asserted for them.

Structure
REQ-034 Package mips_wb_pkg SHALL hold wb_op_t, byte-enable constants BE_ALL=1111, BE_NONE=0000, and load-op predicate function.
REQ-035 Sub-module mips_load_align (combinational op/addr_lo/mem_rdata -> data, enables, err) SHALL be instantiated between M and W.

Verification
REQ-036 ALU, rd=5, alu_res=0x0000ABCD -> 2 edges later Rd_addr=5, Rd_in=0x0000ABCD, enables 1111.
REQ-037 LB addr_lo=2, mem_rdata=0x1280FF34 -> Rd_in=0xFFFFFF80; LBU same -> 0x00000080.
REQ-038 LWL addr_lo=1, mem_rdata=0xAABBCCDD -> Rd_in=0xCCDD0000, enables 1100; LWR addr_lo=2 -> Rd_in=0x0000AABB, enables 0011; without WB_LWLR_EN -> exc=1, enables 0000.
REQ-039 LW addr_lo=2 -> exc pulse, enables 0000; LH rd=0 aligned -> no write, no exc.
REQ-040 Back-to-back LW rd=3 then ALU rd=4 with flush in 2nd cycle -> LW dropped, ALU written; ld_busy=1, ld_busy_rd=3 in the LW M cycle.
REQ-041 rst asserted with LW in M -> no write, all outputs 0 next cycle.
